// File: rtl/memory_access.sv
// MEM pipeline stage: registers EX/MEM results, performs word loads/stores on an internal
// data memory with a fixed multi-cycle access latency, and resolves conditional branches.
module memory_access #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [31:0] result_in,
    input  logic [31:0] registro_2_in,
    input  logic [4:0]  reg_dest_in,
    input  logic [10:0] jump_dest_addr_in,
    input  logic        zero_signal_in,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  reg_dest_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic        PCSrc_out,
    output logic [10:0] jump_dest_addr_out,
    output logic        stall_out
);

    localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              start, complete, busy;

    logic              lat_read, lat_write, lat_branch, lat_memtoreg, lat_regwrite, lat_zero;
    logic [31:0]       lat_result, lat_wdata;
    logic [4:0]        lat_reg_dest;
    logic [10:0]       lat_jump;

    logic              op_read, op_write, op_branch, op_memtoreg, op_regwrite, op_zero;
    logic [31:0]       op_result, op_wdata;
    logic [4:0]        op_reg_dest;
    logic [10:0]       op_jump;
    logic [ADDR_BITS-1:0] op_index;

    logic [31:0]       mem [MEM_DEPTH];

    assign busy = (state_q == StBusy);

    // Completion in BUSY works from the latched instruction; otherwise from the live inputs.
    assign op_read     = busy ? lat_read     : MemRead;
    assign op_write    = busy ? lat_write    : MemWrite;
    assign op_branch   = busy ? lat_branch   : Branch;
    assign op_memtoreg = busy ? lat_memtoreg : MemtoReg;
    assign op_regwrite = busy ? lat_regwrite : RegWrite;
    assign op_zero     = busy ? lat_zero     : zero_signal_in;
    assign op_result   = busy ? lat_result   : result_in;
    assign op_wdata    = busy ? lat_wdata    : registro_2_in;
    assign op_reg_dest = busy ? lat_reg_dest : reg_dest_in;
    assign op_jump     = busy ? lat_jump     : jump_dest_addr_in;
    assign op_index    = op_result[ADDR_BITS-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if ((MemRead || MemWrite) && (MEM_LATENCY > 1)) begin
                    start   = 1'b1;
                    state_d = StBusy;
                    cnt_d   = CntW'(MEM_LATENCY - 1);
                end else begin
                    complete = 1'b1;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            stall_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stall_out <= (state_d == StBusy);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lat_read           <= 1'b0;
            lat_write          <= 1'b0;
            lat_branch         <= 1'b0;
            lat_memtoreg       <= 1'b0;
            lat_regwrite       <= 1'b0;
            lat_zero           <= 1'b0;
            lat_result         <= '0;
            lat_wdata          <= '0;
            lat_reg_dest       <= '0;
            lat_jump           <= '0;
            read_data_out      <= '0;
            alu_result_out     <= '0;
            reg_dest_out       <= '0;
            MemtoReg_out       <= 1'b0;
            RegWrite_out       <= 1'b0;
            PCSrc_out          <= 1'b0;
            jump_dest_addr_out <= '0;
        end else begin
            if (start) begin
                lat_read     <= MemRead;
                lat_write    <= MemWrite;
                lat_branch   <= Branch;
                lat_memtoreg <= MemtoReg;
                lat_regwrite <= RegWrite;
                lat_zero     <= zero_signal_in;
                lat_result   <= result_in;
                lat_wdata    <= registro_2_in;
                lat_reg_dest <= reg_dest_in;
                lat_jump     <= jump_dest_addr_in;
                RegWrite_out <= 1'b0;
                MemtoReg_out <= 1'b0;
                PCSrc_out    <= 1'b0;
            end
            if (complete) begin
                alu_result_out     <= op_result;
                reg_dest_out       <= op_reg_dest;
                MemtoReg_out       <= op_memtoreg;
                RegWrite_out       <= op_regwrite;
                PCSrc_out          <= op_branch & op_zero;
                jump_dest_addr_out <= op_jump;
                // A simultaneous read+write is a store; read data holds.
                if (!op_write && op_read) begin
                    read_data_out <= mem[op_index];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (complete && op_write) begin
            mem[op_index] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed test-plan cases plus a randomized instruction
// stream, checked against an instruction-level reference model (latency 2 and latency 4 DUTs).
module tb_memory_access;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        MemRead, MemWrite, Branch, MemtoReg, RegWrite, zero_signal_in;
    logic [31:0] result_in, registro_2_in;
    logic [4:0]  reg_dest_in;
    logic [10:0] jump_dest_addr_in;

    logic [31:0] rd_a, alu_a, rd_b, alu_b;
    logic [4:0]  dst_a, dst_b;
    logic [10:0] jd_a, jd_b;
    logic        m2r_a, rw_a, pc_a, st_a, m2r_b, rw_b, pc_b, st_b;

    memory_access #(.MEM_DEPTH(256), .ADDR_BITS(8), .MEM_LATENCY(2)) dut (
        .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .result_in(result_in),
        .registro_2_in(registro_2_in), .reg_dest_in(reg_dest_in),
        .jump_dest_addr_in(jump_dest_addr_in), .zero_signal_in(zero_signal_in),
        .read_data_out(rd_a), .alu_result_out(alu_a), .reg_dest_out(dst_a),
        .MemtoReg_out(m2r_a), .RegWrite_out(rw_a), .PCSrc_out(pc_a),
        .jump_dest_addr_out(jd_a), .stall_out(st_a)
    );

    memory_access #(.MEM_DEPTH(256), .ADDR_BITS(8), .MEM_LATENCY(4)) dut4 (
        .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .result_in(result_in),
        .registro_2_in(registro_2_in), .reg_dest_in(reg_dest_in),
        .jump_dest_addr_in(jump_dest_addr_in), .zero_signal_in(zero_signal_in),
        .read_data_out(rd_b), .alu_result_out(alu_b), .reg_dest_out(dst_b),
        .MemtoReg_out(m2r_b), .RegWrite_out(rw_b), .PCSrc_out(pc_b),
        .jump_dest_addr_out(jd_b), .stall_out(st_b)
    );

    // Which instance is under test, and its access latency.
    int sel = 0;
    int lat = 2;

    logic [31:0] o_rd, o_alu;
    logic [4:0]  o_dst;
    logic [10:0] o_jd;
    logic        o_m2r, o_rw, o_pc, o_st;

    always_comb begin
        o_rd  = (sel == 1) ? rd_b  : rd_a;
        o_alu = (sel == 1) ? alu_b : alu_a;
        o_dst = (sel == 1) ? dst_b : dst_a;
        o_jd  = (sel == 1) ? jd_b  : jd_a;
        o_m2r = (sel == 1) ? m2r_b : m2r_a;
        o_rw  = (sel == 1) ? rw_b  : rw_a;
        o_pc  = (sel == 1) ? pc_b  : pc_a;
        o_st  = (sel == 1) ? st_b  : st_a;
    end

    // Reference model state: memory image and expected outputs.
    logic [31:0] mm [256];
    logic [31:0] exp_rd, exp_alu;
    logic [4:0]  exp_dst;
    logic [10:0] exp_jd;
    logic        exp_m2r, exp_rw, exp_pc, exp_st;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".read_data"}, o_rd, exp_rd);
        chk({tag, ".alu_result"}, o_alu, exp_alu);
        chk({tag, ".reg_dest"}, 32'(o_dst), 32'(exp_dst));
        chk({tag, ".jump_dest"}, 32'(o_jd), 32'(exp_jd));
        chk({tag, ".MemtoReg"}, 32'(o_m2r), 32'(exp_m2r));
        chk({tag, ".RegWrite"}, 32'(o_rw), 32'(exp_rw));
        chk({tag, ".PCSrc"}, 32'(o_pc), 32'(exp_pc));
        chk({tag, ".stall"}, 32'(o_st), 32'(exp_st));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mm[i] = '0;
        exp_rd = '0; exp_alu = '0; exp_dst = '0; exp_jd = '0;
        exp_m2r = 1'b0; exp_rw = 1'b0; exp_pc = 1'b0; exp_st = 1'b0;
    endtask

    task automatic set_inputs(input logic rd, wr, br, m2r, rw, z, input logic [31:0] res, wd,
                              input logic [4:0] dst, input logic [10:0] jd);
        MemRead = rd; MemWrite = wr; Branch = br; MemtoReg = m2r; RegWrite = rw;
        zero_signal_in = z; result_in = res; registro_2_in = wd; reg_dest_in = dst;
        jump_dest_addr_in = jd;
    endtask

    task automatic scramble();
        set_inputs(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom, $urandom, 5'($urandom), 11'($urandom));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0, 11'h0);
        @(posedge clock); #1;
        model_reset();
        chk_all(tag);
        reset = 1'b1;
    endtask

    // One instruction: sampled on the next edge, checked through bubble/busy to completion.
    task automatic issue(input string tag, input logic rd, wr, br, m2r, rw, z,
                         input logic [31:0] res, wd, input logic [4:0] dst, input logic [10:0] jd);
        @(negedge clock);
        set_inputs(rd, wr, br, m2r, rw, z, res, wd, dst, jd);
        @(posedge clock); #1;
        if ((rd || wr) && lat > 1) begin
            exp_rw = 1'b0; exp_m2r = 1'b0; exp_pc = 1'b0; exp_st = 1'b1;
            chk_all({tag, "/bubble"});
            scramble();
            for (int c = 2; c < lat; c++) begin
                @(posedge clock); #1;
                chk_all({tag, "/busy"});
            end
            @(posedge clock); #1;
        end
        exp_alu = res; exp_dst = dst; exp_jd = jd; exp_m2r = m2r; exp_rw = rw;
        exp_pc = br & z; exp_st = 1'b0;
        if (wr) mm[res[7:0]] = wd;
        else if (rd) exp_rd = mm[res[7:0]];
        chk_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'h0, 11'h0);
        model_reset();

        // Latency-2 instance.
        sel = 0; lat = 2;
        do_reset("reset");
        issue("store5", 0, 1, 0, 0, 0, 0, 32'd5, 32'hDEADBEEF, 5'd0, 11'h0);
        issue("load5", 1, 0, 0, 1, 1, 0, 32'd5, 32'h0, 5'd2, 11'h0);
        issue("pass", 0, 0, 0, 0, 1, 0, 32'd4, 32'h0, 5'd7, 11'h0);
        issue("br_taken", 0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 5'd0, 11'h2A);
        issue("br_not", 0, 0, 1, 0, 0, 0, 32'h8, 32'h0, 5'd1, 11'h13);
        issue("wrap_st", 0, 1, 0, 0, 0, 0, 32'h105, 32'h11, 5'd0, 11'h0);
        issue("wrap_ld", 1, 0, 0, 1, 1, 0, 32'h5, 32'h0, 5'd9, 11'h0);
        issue("both", 1, 1, 0, 0, 0, 0, 32'd3, 32'h77, 5'd0, 11'h0);
        issue("both_ld", 1, 0, 0, 1, 1, 0, 32'd3, 32'h0, 5'd4, 11'h0);
        issue("mem_br", 1, 0, 1, 1, 1, 1, 32'd3, 32'h0, 5'd6, 11'h7FF);

        for (int n = 0; n < 80; n++) begin
            int kind;
            logic [31:0] addr;
            kind = $urandom_range(0, 4);
            addr = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7));
            issue("rand", (kind == 1 || kind == 3), (kind == 2 || kind == 3), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), addr, $urandom, 5'($urandom),
                  11'($urandom));
        end

        // Latency-4 instance: reset during the second busy cycle of a store.
        sel = 1; lat = 4;
        do_reset("reset4");
        issue("l4_pass", 0, 0, 1, 1, 1, 1, 32'h1234, 32'h0, 5'd3, 11'h15);
        issue("l4_st9", 0, 1, 0, 0, 0, 0, 32'd9, 32'h33, 5'd0, 11'h0);
        issue("l4_ld9", 1, 0, 0, 1, 1, 0, 32'd9, 32'h0, 5'd8, 11'h0);
        @(negedge clock);
        set_inputs(0, 1, 0, 0, 1, 0, 32'd9, 32'h55, 5'd5, 11'h3);
        @(posedge clock); #1;
        exp_rw = 1'b0; exp_m2r = 1'b0; exp_pc = 1'b0; exp_st = 1'b1;
        chk_all("abort/bubble");
        @(posedge clock); #1;
        chk_all("abort/busy2");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        model_reset();
        chk_all("abort/reset");
        reset = 1'b1;
        issue("abort_ld9", 1, 0, 0, 1, 1, 0, 32'd9, 32'h0, 5'd8, 11'h0);
        issue("l4_st_ld_st", 0, 1, 0, 0, 0, 0, 32'h209, 32'hCAFE, 5'd0, 11'h0);
        issue("l4_raw", 1, 0, 0, 1, 1, 0, 32'd9, 32'h0, 5'd1, 11'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
